// File: rtl/fft_pkg.sv
// Shared constants, complex-sample type and the W16 twiddle ROM for the 16-point radix-4 FFT.
package fft_pkg;

    localparam int FFT_DATA_W  = 32;
    localparam int FFT_TW_W    = 16;
    localparam int FFT_TW_FRAC = 14;
    localparam int FFT_TW_N    = 10;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [FFT_TW_W-1:0] c;
        logic signed [FFT_TW_W-1:0] s;
    } tw_t;

    // Q1.14 (cos, -sin) of 2*pi*e/16 for every exponent e = q*k reachable with q, k in 0..3.
    localparam tw_t TW_ROM [FFT_TW_N] = '{
        '{16'sd16384,  16'sd0},
        '{16'sd15137, -16'sd6270},
        '{16'sd11585, -16'sd11585},
        '{16'sd6270,  -16'sd15137},
        '{16'sd0,     -16'sd16384},
        '{-16'sd6270, -16'sd15137},
        '{-16'sd11585, -16'sd11585},
        '{-16'sd15137, -16'sd6270},
        '{-16'sd16384, 16'sd0},
        '{-16'sd15137, 16'sd6270}
    };

    function automatic tw_t tw_lookup(input logic [3:0] e);
        return (e < 4'(FFT_TW_N)) ? TW_ROM[e] : TW_ROM[0];
    endfunction

endpackage

// File: rtl/fft_cmul_lane.sv
// One twiddle lane: registered partial products, then add/sub, scale, saturate.
// FFT_TWIDDLE_ROUND_EN selects round-half-up before the shift; default truncates toward -inf.
module fft_cmul_lane
    import fft_pkg::*;
#(
    parameter int K       = 0,
    parameter int DATA_W  = FFT_DATA_W,
    parameter int TW_W    = FFT_TW_W,
    parameter int TW_FRAC = FFT_TW_FRAC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture,
    input  logic                     advance,
    input  logic [1:0]               q,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_im,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     ovf
);

    localparam int PROD_W = DATA_W + TW_W;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef FFT_TWIDDLE_ROUND_EN
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) << (TW_FRAC - 1);
`else
    localparam logic signed [SUM_W-1:0] RND = '0;
`endif

    // Bit DATA_W of the result flags that the value was clamped.
    function automatic logic [DATA_W:0] scale_sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] sh;
        sh = (s + RND) >>> TW_FRAC;
        if (sh > SAT_MAX) begin
            return {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (sh < SAT_MIN) begin
            return {1'b1, SAT_MIN[DATA_W-1:0]};
        end
        return {1'b0, sh[DATA_W-1:0]};
    endfunction

    logic [3:0] e;
    tw_t        tw;

    logic signed [PROD_W-1:0] ac, bd, ad, bc;

    logic signed [DATA_W-1:0] res_real, res_im;
    logic                     sat_real, sat_im;

    always_comb begin
        e  = 4'(q) * 4'(K);
        tw = tw_lookup(e);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ac <= '0;
            bd <= '0;
            ad <= '0;
            bc <= '0;
        end else if (capture) begin
            ac <= PROD_W'(in_real) * PROD_W'(tw.c);
            bd <= PROD_W'(in_im)   * PROD_W'(tw.s);
            ad <= PROD_W'(in_real) * PROD_W'(tw.s);
            bc <= PROD_W'(in_im)   * PROD_W'(tw.c);
        end
    end

    always_comb begin
        {sat_real, res_real} = scale_sat(SUM_W'(ac) - SUM_W'(bd));
        {sat_im, res_im}     = scale_sat(SUM_W'(ad) + SUM_W'(bc));
    end

    // Outputs hold between valid groups; ovf only pulses on a valid result.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_real <= '0;
            out_im   <= '0;
            ovf      <= 1'b0;
        end else if (advance) begin
            out_real <= res_real;
            out_im   <= res_im;
            ovf      <= sat_real | sat_im;
        end else begin
            ovf      <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_twiddle_stage.sv
// Four-lane W16^(q*k) twiddle multiplier, 2-cycle latency, one group per cycle.
// FFT_TWIDDLE_ROUND_EN enables round-half-up scaling in every lane.
module fft_twiddle_stage
    import fft_pkg::*;
#(
    parameter int DATA_W  = FFT_DATA_W,
    parameter int TW_W    = FFT_TW_W,
    parameter int TW_FRAC = FFT_TW_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        q,
    input  logic [DATA_W-1:0] in0_real,
    input  logic [DATA_W-1:0] in1_real,
    input  logic [DATA_W-1:0] in2_real,
    input  logic [DATA_W-1:0] in3_real,
    input  logic [DATA_W-1:0] in0_im,
    input  logic [DATA_W-1:0] in1_im,
    input  logic [DATA_W-1:0] in2_im,
    input  logic [DATA_W-1:0] in3_im,
    output logic              out_valid,
    output logic [1:0]        q_out,
    output logic [DATA_W-1:0] out0_real,
    output logic [DATA_W-1:0] out1_real,
    output logic [DATA_W-1:0] out2_real,
    output logic [DATA_W-1:0] out3_real,
    output logic [DATA_W-1:0] out0_im,
    output logic [DATA_W-1:0] out1_im,
    output logic [DATA_W-1:0] out2_im,
    output logic [DATA_W-1:0] out3_im,
    output logic              ovf
);

    // Handshake: in_valid qualifies q and all lanes in the cycle it is high; there is no
    // ready, every cycle is accepted, and out_valid marks the matching result 2 cycles later.
    cplx_t      din  [4];
    cplx_t      dout [4];
    logic [3:0] lane_ovf;

    logic       valid_d1;
    logic [1:0] q_d1;

    always_comb begin
        din[0] = '{re: in0_real, im: in0_im};
        din[1] = '{re: in1_real, im: in1_im};
        din[2] = '{re: in2_real, im: in2_im};
        din[3] = '{re: in3_real, im: in3_im};
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        fft_cmul_lane #(
            .K       (k),
            .DATA_W  (DATA_W),
            .TW_W    (TW_W),
            .TW_FRAC (TW_FRAC)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .capture  (in_valid),
            .advance  (valid_d1),
            .q        (q),
            .in_real  (din[k].re),
            .in_im    (din[k].im),
            .out_real (dout[k].re),
            .out_im   (dout[k].im),
            .ovf      (lane_ovf[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_d1  <= 1'b0;
            q_d1      <= '0;
            out_valid <= 1'b0;
            q_out     <= '0;
        end else begin
            valid_d1  <= in_valid;
            out_valid <= valid_d1;
            if (in_valid) begin
                q_d1 <= q;
            end
            if (valid_d1) begin
                q_out <= q_d1;
            end
        end
    end

    assign ovf       = |lane_ovf;
    assign out0_real = dout[0].re;
    assign out1_real = dout[1].re;
    assign out2_real = dout[2].re;
    assign out3_real = dout[3].re;
    assign out0_im   = dout[0].im;
    assign out1_im   = dout[1].im;
    assign out2_im   = dout[2].im;
    assign out3_im   = dout[3].im;

endmodule

// File: tb/tb_fft_twiddle_stage.sv
// Bench for fft_twiddle_stage: directed vector table, hand-written stream/reset sequences,
// and random traffic against an arithmetic reference model.
module tb_fft_twiddle_stage;

    typedef logic [7:0][31:0] lanes_t;  // index 2k = lane k real, 2k+1 = lane k imag

    typedef struct packed {
        logic   chk;
        logic   valid;
        logic   [1:0] q;
        logic   ovf;
        lanes_t d;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

`ifdef FFT_TWIDDLE_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    localparam int MAXI = 2147483647;
    localparam int MINI = int'(32'h8000_0000);

    localparam int TW_C [10] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137, -16384, -15137};
    localparam int TW_S [10] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270, 0, 6270};

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] q;
    lanes_t     in_d;
    logic       out_valid;
    logic [1:0] q_out;
    lanes_t     out_d;
    logic       ovf;

    logic [REC_W-1:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fft_twiddle_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .q         (q),
        .in0_real  (in_d[0]),
        .in1_real  (in_d[2]),
        .in2_real  (in_d[4]),
        .in3_real  (in_d[6]),
        .in0_im    (in_d[1]),
        .in1_im    (in_d[3]),
        .in2_im    (in_d[5]),
        .in3_im    (in_d[7]),
        .out_valid (out_valid),
        .q_out     (q_out),
        .out0_real (out_d[0]),
        .out1_real (out_d[2]),
        .out2_real (out_d[4]),
        .out3_real (out_d[6]),
        .out0_im   (out_d[1]),
        .out1_im   (out_d[3]),
        .out2_im   (out_d[5]),
        .out3_im   (out_d[7]),
        .ovf       (ovf)
    );

    // ---------------- reference model ----------------
    function automatic logic [32:0] scale(input longint s);
        longint t;
        t = ROUND ? s + 64'sd8192 : s;
        t = t >>> 14;
        if (t > longint'(MAXI)) return {1'b1, 32'h7fff_ffff};
        if (t < longint'(MINI)) return {1'b1, 32'h8000_0000};
        return {1'b0, 32'(t)};
    endfunction

    function automatic rec_t model(input bit v, input logic [1:0] qq, input lanes_t l);
        rec_t r;
        r = '0;
        if (!v) return r;
        r.chk   = 1'b1;
        r.valid = 1'b1;
        r.q     = qq;
        for (int k = 0; k < 4; k++) begin
            int e;
            longint a, b, c, d;
            logic [32:0] sr, si;
            e  = int'(qq) * k;
            a  = longint'($signed(l[2*k]));
            b  = longint'($signed(l[2*k+1]));
            c  = longint'(TW_C[e]);
            d  = longint'(TW_S[e]);
            sr = scale(a * c - b * d);
            si = scale(a * d + b * c);
            r.d[2*k]   = sr[31:0];
            r.d[2*k+1] = si[31:0];
            r.ovf      = r.ovf | sr[32] | si[32];
        end
        return r;
    endfunction

    function automatic lanes_t mk(input int r0, i0, r1, i1, r2, i2, r3, i3);
        lanes_t l;
        l[0] = r0; l[1] = i0; l[2] = r1; l[3] = i1;
        l[4] = r2; l[5] = i2; l[6] = r3; l[7] = i3;
        return l;
    endfunction

    function automatic lanes_t rand_lanes(input bit wide);
        lanes_t l;
        for (int i = 0; i < 8; i++) begin
            l[i] = wide ? 32'($urandom) : 32'($urandom_range(0, 4000)) - 32'd2000;
        end
        return l;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input rec_t e);
        n_assert++;
        if (out_valid !== e.valid) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e.valid);
        end
        n_assert++;
        if (ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL ovf cyc=%0d got=%b exp=%b", cyc, ovf, e.ovf);
        end
        if (e.chk) begin
            n_assert++;
            if (q_out !== e.q) begin
                n_fail++;
                $display("FAIL q_out cyc=%0d got=%0d exp=%0d", cyc, q_out, e.q);
            end
            for (int i = 0; i < 8; i++) begin
                n_assert++;
                if (out_d[i] !== e.d[i]) begin
                    n_fail++;
                    $display("FAIL lane%0d_%s cyc=%0d got=%0d exp=%0d", i / 2,
                             (i % 2) ? "im" : "real", cyc, $signed(out_d[i]), $signed(e.d[i]));
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    // Drive one cycle of inputs and check the outputs produced by the previous cycle's inputs.
    task automatic cycle(input bit rst, input bit v, input logic [1:0] qq, input lanes_t l,
                         input rec_t e);
        rec_t zero_chk;
        zero_chk     = '0;
        zero_chk.chk = 1'b1;
        reset    = rst;
        in_valid = v;
        q        = qq;
        in_d     = l;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(zero_chk);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check(rec_t'(exp_q.pop_front()));
        if (rst) exp_q.push_back('0);
    endtask

    task automatic drive(input bit v, input logic [1:0] qq, input lanes_t l);
        cycle(1'b0, v, qq, l, model(v, qq, l));
    endtask

    task automatic idle();
        drive(1'b0, 2'($urandom_range(0, 3)), rand_lanes(1'b1));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0] q;
        lanes_t     din;
        lanes_t     dout;
        logic       ovf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rec_t r;

        tbl[0] = '{2'd0, mk(1, 2, 3, 4, 5, 6, 7, 8), mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0};
        tbl[1] = '{2'd1, mk(0, 0, 0, 0, 16384, 0, 0, 0), mk(0, 0, 0, 0, 11585, -11585, 0, 0), 1'b0};
        tbl[2] = '{2'd2, mk(9, -7, 0, 0, 3, 5, 0, 0), mk(9, -7, 0, 0, 5, -3, 0, 0), 1'b0};
        tbl[3] = '{2'd1, mk(0, 0, 1, 0, 0, 0, 0, 0),
                   ROUND ? mk(0, 0, 1, 0, 0, 0, 0, 0) : mk(0, 0, 0, -1, 0, 0, 0, 0), 1'b0};
        tbl[4] = '{2'd1, mk(-5, 100, 0, 0, MAXI, MAXI, 0, 0), mk(-5, 100, 0, 0, MAXI, 0, 0, 0), 1'b1};
        tbl[5] = '{2'd3, mk(0, 0, 0, 0, 0, 0, 16384, 0), mk(0, 0, 0, 0, 0, 0, -15137, 6270), 1'b0};
        tbl[6] = '{2'd2, mk(0, 0, 0, 0, MINI, MINI, 0, 0), mk(0, 0, 0, 0, MINI, MAXI, 0, 0), 1'b1};
        tbl[7] = '{2'd3, mk(0, 0, 0, 0, MAXI, MAXI, 0, 0), mk(0, 0, 0, 0, 0, MINI, 0, 0), 1'b1};

        // Reset state: all outputs zero after the first reset edge.
        cycle(1'b1, 1'b0, 2'd0, '0, '0);
        cycle(1'b1, 1'b0, 2'd0, '0, '0);
        idle();

        // Each vector surrounded by idles so out_valid is seen high only at t+2.
        for (int i = 0; i < 8; i++) begin
            r       = '0;
            r.chk   = 1'b1;
            r.valid = 1'b1;
            r.q     = tbl[i].q;
            r.ovf   = tbl[i].ovf;
            r.d     = tbl[i].dout;
            cycle(1'b0, 1'b1, tbl[i].q, tbl[i].din, r);
            idle();
        end
        idle();

        // Continuous stream with q wrapping 3 -> 0: no bubble expected.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i % 4), rand_lanes(i[0]));
        end
        idle();
        idle();

        // Reset right behind two valid groups flushes both.
        drive(1'b1, 2'd1, rand_lanes(1'b0));
        cycle(1'b1, 1'b1, 2'd2, rand_lanes(1'b0), '0);
        for (int i = 0; i < 3; i++) idle();

        // Random traffic, mixed widths, random bubbles.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  rand_lanes($urandom_range(0, 1) == 1));
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
